alu_seq: RTL

//  Parametrised sequential ALU, successor to the 4-bit combinational ALU.

---
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: WIDTH-bit operands, 2*WIDTH-bit result, valid/ready on both sides.
// Define ALU_MULDIV_EN to build the iterative MUL/DIV datapath; otherwise opcodes 2/3 flag err.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           alu_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   alu_out,
    output logic                 carry_out,
    output logic                 err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_ROL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_NAND = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_GT   = 4'd14;
    localparam logic [3:0] OP_EQ   = 4'd15;

    // state | meaning:  IDLE | accepting  BUSY | mul/div iterating  DONE | result held for sink
`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

    state_t state;

    logic [SHAMT_W-1:0]  shamt;
    logic [WIDTH:0]      add_w;
    logic [WIDTH:0]      sub_w;
    logic [WIDTH:0]      shl_w;
    logic [WIDTH:0]      shr_w;
    logic [2*WIDTH-1:0]  rol_w;
    logic [2*WIDTH-1:0]  ror_w;
    logic [2*WIDTH-1:0]  res_c;
    logic                carry_c;
    logic                err_c;

    assign shamt = b[SHAMT_W-1:0];
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};
    assign shl_w = {1'b0, a} << shamt;
    assign shr_w = {a, 1'b0} >> shamt;
    assign rol_w = {a, a} << shamt;
    assign ror_w = {a, a} >> shamt;

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        err_c   = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                res_c[WIDTH:0] = add_w;
                carry_c        = add_w[WIDTH];
            end
            OP_SUB: begin
                res_c[WIDTH-1:0] = sub_w[WIDTH-1:0];
                carry_c          = sub_w[WIDTH];
            end
            OP_MUL, OP_DIV: err_c = 1'b1;
            OP_SHL: begin
                res_c[WIDTH-1:0] = shl_w[WIDTH-1:0];
                carry_c          = shl_w[WIDTH];
            end
            OP_SHR: begin
                res_c[WIDTH-1:0] = shr_w[WIDTH:1];
                carry_c          = shr_w[0];
            end
            OP_ROL:  res_c[WIDTH-1:0] = rol_w[2*WIDTH-1:WIDTH];
            OP_ROR:  res_c[WIDTH-1:0] = ror_w[WIDTH-1:0];
            OP_AND:  res_c[WIDTH-1:0] = a & b;
            OP_OR:   res_c[WIDTH-1:0] = a | b;
            OP_XOR:  res_c[WIDTH-1:0] = a ^ b;
            OP_NOR:  res_c[WIDTH-1:0] = ~(a | b);
            OP_NAND: res_c[WIDTH-1:0] = ~(a & b);
            OP_XNOR: res_c[WIDTH-1:0] = ~(a ^ b);
            OP_GT:   res_c[0] = (a > b);
            OP_EQ:   res_c[0] = (a == b);
            default: res_c = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    // hi/lo are shared: MUL keeps partial product in hi and multiplier in lo,
    // DIV keeps the partial remainder in hi and the dividend/quotient in lo.
    logic                is_div;
    logic [WIDTH-1:0]    opnd_b;
    logic [WIDTH-1:0]    hi;
    logic [WIDTH-1:0]    lo;
    logic [CNT_W-1:0]    cnt;

    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_shift;
    logic                div_ge;
    logic [WIDTH-1:0]    div_diff;
    logic [WIDTH-1:0]    hi_nxt;
    logic [WIDTH-1:0]    lo_nxt;

    always_comb begin
        mul_sum   = {1'b0, hi} + {1'b0, ({WIDTH{lo[0]}} & opnd_b)};
        div_shift = {hi, lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_b});
        div_diff  = div_shift[WIDTH-1:0] - opnd_b;
        if (is_div) begin
            hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            alu_out   <= '0;
            carry_out <= 1'b0;
            err       <= 1'b0;
`ifdef ALU_MULDIV_EN
            is_div    <= 1'b0;
            opnd_b    <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef ALU_MULDIV_EN
                        if (alu_sel == OP_MUL || alu_sel == OP_DIV) begin
                            state  <= BUSY;
                            is_div <= (alu_sel == OP_DIV);
                            opnd_b <= b;
                            hi     <= '0;
                            lo     <= a;
                            cnt    <= CNT_W'(WIDTH);
                        end else
`endif
                        begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            alu_out   <= res_c;
                            carry_out <= carry_c;
                            err       <= err_c;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                BUSY: begin
                    if (cnt != '0) begin
                        hi  <= hi_nxt;
                        lo  <= lo_nxt;
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        alu_out   <= {hi, lo};
                        carry_out <= 1'b0;
                        err       <= is_div && (opnd_b == '0);
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
